// File: rtl/div_iter.sv
// Iterative 32-bit unsigned restoring divider, RADIX_BITS quotient bits per cycle.
// Ports: clk, resetn (async low), valid, a, b in; done, c = {rem, quo} out.
module div_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] c
);

  if (!(RADIX_BITS == 1 ||
        RADIX_BITS == 2 ||
        RADIX_BITS == 4)) begin : g_bad_radix
    $error("div_iter: RADIX_BITS must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [5:0] STEP = 6'(RADIX_BITS);
  localparam logic [5:0] LAST = 6'(32 - RADIX_BITS);

  state_t      state;
  logic [31:0] dq;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [5:0]  cnt;

  logic [32:0] r_w;
  logic [31:0] d_w;
  logic [31:0] dq_nxt;
  logic [31:0] rem_nxt;

  // Dividend shifts out of dq's MSB while quotient
  // bits shift into its LSB, so dq ends as quotient.
  always_comb begin
    r_w = {1'b0, rem};
    d_w = dq;
    for (int i = 0; i < RADIX_BITS; i++) begin
      r_w = {r_w[31:0], d_w[31]};
      d_w = {d_w[30:0], 1'b0};
      if (r_w >= {1'b0, dvs}) begin
        r_w    = r_w - {1'b0, dvs};
        d_w[0] = 1'b1;
      end
    end
    rem_nxt = r_w[31:0];
    dq_nxt  = d_w;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      dq    <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      c     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            dq    <= a;
            dvs   <= b;
            rem   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!valid) begin
            state <= IDLE;
          end else begin
            dq  <= dq_nxt;
            rem <= rem_nxt;
            cnt <= cnt + STEP;
            if (cnt == LAST) begin
              c     <= {rem_nxt, dq_nxt};
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (valid) begin
            dq    <= a;
            dvs   <= b;
            rem   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter at RADIX_BITS 1, 2 and 4.
// Stimulus pushes expected results; monitors pop on done.
module tb_div_iter;

  typedef struct {
    logic [63:0] c;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [2:0]  v;
  logic [31:0] aa [3];
  logic [31:0] bb [3];
  logic [2:0]  dn;
  logic [63:0] cc [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  div_iter #(.RADIX_BITS(1)) u_r1 (
    .clk(clk), .resetn(resetn), .valid(v[0]),
    .a(aa[0]), .b(bb[0]), .done(dn[0]), .c(cc[0])
  );
  div_iter #(.RADIX_BITS(2)) u_r2 (
    .clk(clk), .resetn(resetn), .valid(v[1]),
    .a(aa[1]), .b(bb[1]), .done(dn[1]), .c(cc[1])
  );
  div_iter #(.RADIX_BITS(4)) u_r4 (
    .clk(clk), .resetn(resetn), .valid(v[2]),
    .a(aa[2]), .b(bb[2]), .done(dn[2]), .c(cc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int k);
    case (k)
      0:       return 33;
      1:       return 17;
      default: return 9;
    endcase
  endfunction

  function automatic logic [63:0] ref_div(logic [31:0] x, logic [31:0] y);
    if (y == 0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  function automatic void qpush(int k, exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int k);
    case (k)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(int k);
    exp_t e;
    n_cmp++;
    if (qsize(k) == 0) begin
      n_bad++;
      $display("FAIL spurious_done r%0d: done at cycle %0d, none expected",
               k, cyc);
    end else begin
      e = qpop(k);
      if (cc[k] !== e.c || cyc != e.cyc) begin
        n_bad++;
        $display("FAIL result r%0d: got c=%h cyc=%0d want c=%h cyc=%0d",
                 k, cc[k], cyc, e.c, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      for (int k = 0; k < 3; k++) begin
        if (dn[k]) mon(k);
      end
    end
  end

  task automatic wait_done(int k, bit scr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lat_of(k) + 4 && !seen; i++) begin
      @(negedge clk);
      if (dn[k]) seen = 1'b1;
      else if (scr) begin
        aa[k] = $urandom;
        bb[k] = $urandom;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout r%0d: done=0 want done=1 by cycle %0d", k, cyc);
    end
  endtask

  // Called at a negedge; that cycle is cycle 0 of the request.
  task automatic issue(int k, logic [31:0] x, logic [31:0] y,
                       bit keep, bit scr);
    exp_t e;
    aa[k] = x;
    bb[k] = y;
    v[k]  = 1'b1;
    e.c   = ref_div(x, y);
    e.cyc = cyc + lat_of(k);
    qpush(k, e);
    wait_done(k, scr);
    if (!keep) v[k] = 1'b0;
  endtask

  task automatic abort_op(int k, logic [31:0] x, logic [31:0] y);
    int n;
    aa[k] = x;
    bb[k] = y;
    v[k]  = 1'b1;
    n = $urandom_range(lat_of(k) - 1, 1);
    repeat (n) @(negedge clk);
    v[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_run(int k, int nops);
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < nops; i++) begin
      x = $urandom >> $urandom_range(8, 0);
      y = $urandom >> $urandom_range(31, 0);
      if ($urandom_range(99, 0) < 5) y = 0;
      if ($urandom_range(9, 0) == 0) abort_op(k, x, y);
      else issue(k, x, y, 1'($urandom_range(1, 0)), 1'b1);
    end
    v[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c_old;
    resetn = 1'b0;
    v      = '0;
    for (int k = 0; k < 3; k++) begin
      aa[k] = '0;
      bb[k] = '0;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_done r%0d", k), 64'(dn[k]), 64'd0);
      chk($sformatf("reset_c r%0d", k), cc[k], 64'd0);
    end

    // Basic then back-to-back with operand churn during BUSY.
    issue(0, 32'd100, 32'd7, 1'b1, 1'b0);
    issue(0, 32'd1000, 32'd10, 1'b0, 1'b1);
    @(negedge clk);

    // Divide by zero and extremes on every radix.
    for (int k = 0; k < 3; k++) begin
      issue(k, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
      issue(k, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      issue(k, 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
      issue(k, 32'h5, 32'hFFFF_FFFF, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Abort in cycle 10, re-request in cycle 12.
    c_old = cc[0];
    aa[0] = 32'd100;
    bb[0] = 32'd7;
    v[0]  = 1'b1;
    repeat (10) @(negedge clk);
    v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_c_held", cc[0], c_old);
    issue(0, 32'd9, 32'd4, 1'b0, 1'b0);
    chk("abort_then_req_c", cc[0], 64'h0000_0001_0000_0002);
    @(negedge clk);

    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    // Reset in the middle of BUSY.
    aa[0] = 32'd77;
    bb[0] = 32'd3;
    v[0]  = 1'b1;
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midbusy_reset_done", 64'(dn[0]), 64'd0);
    chk("midbusy_reset_c", cc[0], 64'd0);
    chk("reset_c_r4", cc[2], 64'd0);
    v[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      issue(k, 32'd1000, 32'd10, 1'b0, 1'b0);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("leftover r%0d", k), 64'(qsize(k)), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
